// File: rtl/draw_cmd_stack.sv
// draw_cmd_stack: LIFO store for draw commands between producers and the feeder.
// Popped entries land in a registered output that holds until the next accepted
// pop. Status outputs decode from the occupancy register only, so they settle one
// cycle after the push or pop that changed them. DEPTH legal range is 2..256.
module draw_cmd_stack #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic [CNT_WIDTH-1:0]  count,
    input  logic                  clear,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_pop_data;
    logic                  r_pop_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_nonempty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_mem_we;
    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_rd_addr;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop_ok   = pop && w_nonempty;
    // A push on a full stack still fits when the same edge pops the top.
    assign w_push_ok  = push && (!w_full || w_pop_ok);
    assign w_mem_we   = reset_n && !clear && w_push_ok;

    // Simultaneous push+pop overwrites the top slot; a plain push writes above it.
    assign w_wr_addr  = w_pop_ok ? AW'(r_count - ONE_CNT) : AW'(r_count);
    assign w_rd_addr  = AW'(r_count - ONE_CNT);

    // Storage array: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_wr_addr] <= push_data;
        end
    end

    // Occupancy, popped-entry register and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_count     <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_pop_data <= r_mem[w_rd_addr];
            end
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + ONE_CNT;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

    assign pop_data    = r_pop_data;
    assign pop_valid   = r_pop_valid;
    assign count       = r_count;
    assign stack_empty = !w_nonempty;
    assign stack_full  = w_full;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_draw_cmd_stack.sv
// Testbench for draw_cmd_stack: a behavioural LIFO model predicts status each
// cycle, and every accepted pop queues its expected entry for the scoreboard.
module tb_draw_cmd_stack;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset_n, push, pop, clear;
    logic [DW-1:0] push_data;
    logic [DW-1:0] pop_data;
    logic          pop_valid, stack_empty, stack_full, overflow, underflow;
    logic [CW-1:0] count;

    draw_cmd_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .count       (count),
        .clear       (clear),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_stk[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_pd;
    logic          m_ov, m_un, m_pv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic step(input logic rn, input logic cl, input logic p,
                        input logic [DW-1:0] d, input logic q);
        logic [DW-1:0] top;
        logic          was_full;
        @(negedge clock);
        reset_n = rn; clear = cl; push = p; push_data = d; pop = q;
        @(posedge clock);
        m_pv = 1'b0;
        if (!rn) begin
            m_stk.delete(); m_ov = 0; m_un = 0; m_pd = '0;
        end else if (cl) begin
            m_stk.delete(); m_ov = 0; m_un = 0;
        end else begin
            was_full = (m_stk.size() == DEPTH);
            if (q && m_stk.size() > 0) begin
                top = m_stk.pop_back();
                exp_q.push_back(top);
                m_pd = top;
                m_pv = 1'b1;
                if (p) m_stk.push_back(d);
            end else begin
                if (q) m_un = 1'b1;
                if (p) begin
                    if (was_full) m_ov = 1'b1;
                    else m_stk.push_back(d);
                end
            end
        end
        #1;
        chk("count", 64'(count), 64'(m_stk.size()));
        chk("empty", 64'(stack_empty), 64'(m_stk.size() == 0));
        chk("full", 64'(stack_full), 64'(m_stk.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ov));
        chk("underflow", 64'(underflow), 64'(m_un));
        chk("pop_valid", 64'(pop_valid), 64'(m_pv));
        chk("pop_data_held", 64'(pop_data), 64'(m_pd));
        if (pop_valid) begin
            if (exp_q.size() == 0) chk("sb_unexpected_pop", 64'(pop_data), 64'hDEAD_BEEF_0BAD);
            else chk("sb_pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0);
    endtask

    initial begin
        reset_n = 0; clear = 0; push = 0; pop = 0; push_data = '0;
        m_pd = '0; m_ov = 0; m_un = 0; m_pv = 0;
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        idle(5);

        // LIFO ordering with spaced pops
        step(1, 0, 1, 32'hA1, 0);
        step(1, 0, 1, 32'hB2, 0);
        step(1, 0, 1, 32'hC3, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, '0, 1);
            idle(3);
        end
        chk("lifo_last", 64'(pop_data), 64'hA1);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, DW'(i), 0);
        chk("full_count", 64'(count), 64'(DEPTH));
        step(1, 0, 1, 32'h99, 0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        step(1, 0, 0, '0, 1);
        chk("ovf_not_stored", 64'(pop_data), 64'd15);

        // Swap on a full stack keeps count and raises no new overflow
        step(1, 0, 0, '0, 0);
        step(1, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, DW'(32'h100 + i), 0);
        step(1, 0, 1, 32'h5A5A, 1);
        chk("swap_full_pd", 64'(pop_data), 64'h10F);
        chk("swap_full_ovf", 64'(overflow), 64'd0);
        step(1, 0, 0, '0, 1);
        chk("swap_full_next", 64'(pop_data), 64'h5A5A);

        // Underflow on empty, then clear with push/pop ignored
        step(1, 1, 0, '0, 0);
        step(1, 0, 0, '0, 1);
        chk("unf_flag", 64'(underflow), 64'd1);
        step(1, 1, 1, 32'hEE, 1);
        chk("clear_unf", 64'(underflow), 64'd0);
        chk("clear_pd_kept", 64'(pop_data), 64'h5A5A);

        // Swap at count 2
        step(1, 0, 1, 32'h11, 0);
        step(1, 0, 1, 32'h22, 0);
        step(1, 0, 1, 32'h55, 1);
        chk("swap_pd", 64'(pop_data), 64'h22);
        step(1, 0, 0, '0, 1);
        chk("swap_next", 64'(pop_data), 64'h55);
        step(1, 0, 0, '0, 1);

        // Push+pop on empty: push wins, pop flagged, no bypass
        step(1, 0, 1, 32'h77, 1);
        chk("empty_pp_cnt", 64'(count), 64'd1);
        step(1, 0, 0, '0, 1);
        chk("empty_pp_top", 64'(pop_data), 64'h77);

        // Random traffic
        for (int i = 0; i < 200; i++)
            step(1, ($urandom_range(0, 31) == 0), $urandom_range(0, 1),
                 $urandom, $urandom_range(0, 1));

        // Reset mid-sequence with pop asserted
        step(1, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, DW'(32'h300 + i), 0);
        step(0, 0, 0, '0, 1);
        chk("rst_pd", 64'(pop_data), 64'd0);
        idle(2);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
